// File: rtl/terrain_scroller.sv
// Side-scrolling terrain engine: frame-driven scroll offset, ground and coin pixel tests, coin pickup.
// Define TERRAIN_COIN_EN to build the coin logic; without it is_coin, coin_pulse and coins read 0.
module terrain_scroller #(
  parameter int SCREEN_W   = 640,
  parameter int WORLD_LEN  = 4096,
  parameter int SEG_COUNT  = 8,
  // Segment 0 and coin 0 sit in the LSBs, so these lists read right-to-left.
  parameter logic [10*SEG_COUNT-1:0] SEG_HEIGHTS = {10'd300, 10'd360, 10'd479, 10'd360,
                                                    10'd420, 10'd360, 10'd300, 10'd360},
  parameter int COIN_COUNT = 4,
  parameter logic [12*COIN_COUNT-1:0] COIN_POS = {12'd2820, 12'd1400, 12'd820, 12'd400},
  parameter int COIN_R     = 10,
  parameter int COIN_LIFT  = 120,
  parameter int STICK_X    = 120
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_clk,
  input  logic        playing,
  input  logic [2:0]  speed,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic [9:0]  StickY,
  output logic [9:0]  GroundY,
  output logic        is_ground,
  output logic        is_coin,
  output logic [11:0] offset,
  output logic        coin_pulse,
  output logic [7:0]  coins
);

  localparam int          SEG_SHIFT  = $clog2(WORLD_LEN / SEG_COUNT);
  localparam logic [11:0] WORLD_MASK = 12'(WORLD_LEN - 1);

  if (STICK_X >= SCREEN_W) begin : gBadStickX
    $error("STICK_X must lie inside the visible screen");
  end

  typedef enum logic [1:0] {IDLE, SCROLL, CHECK} state_t;

  state_t      state_q;
  logic        sync1_q, sync2_q, sync3_q;
  logic        frameEvt;
  logic [11:0] offset_q, offset_d;
  logic [11:0] stickWorldX, drawWorldX;

  function automatic logic [9:0] heightAt(input logic [11:0] worldX);
    return SEG_HEIGHTS[32'(worldX >> SEG_SHIFT) * 10 +: 10];
  endfunction

  assign frameEvt    = sync2_q & ~sync3_q;
  assign offset_d    = (offset_q + {9'd0, speed}) & WORLD_MASK;
  assign stickWorldX = (offset_q + 12'(STICK_X)) & WORLD_MASK;
  assign drawWorldX  = (offset_q + {2'b00, DrawX}) & WORLD_MASK;
  assign GroundY     = heightAt(stickWorldX);
  assign is_ground   = (DrawY >= heightAt(drawWorldX));
  assign offset      = offset_q;

`ifdef TERRAIN_COIN_EN
  localparam logic signed [21:0] HIT_R2  = 22'(COIN_R * COIN_R);
  localparam logic signed [21:0] GRAB_R2 = 22'(4 * COIN_R * COIN_R);

  logic [COIN_COUNT-1:0] taken_q, grab;
  logic                  coinPulse_q, pixCoin;
  logic [7:0]            coins_q, coins_d, grabCount;
  logic [8:0]            coinSum;

  // Squares use values clamped to +/-1023 so the 22-bit sum never overflows;
  // the clamp cannot alter a hit while the radii stay well below that.
  function automatic logic signed [21:0] sq(input logic signed [13:0] v);
    logic signed [21:0] c;
    if (v > 14'sd1023)       c = 22'sd1023;
    else if (v < -14'sd1023) c = -22'sd1023;
    else                     c = {{8{v[13]}}, v};
    return c * c;
  endfunction

  always_comb begin
    logic [11:0]        cx, sxU;
    logic signed [13:0] sx, cy;
    pixCoin   = 1'b0;
    grab      = '0;
    grabCount = '0;
    cx        = '0;
    sxU       = '0;
    sx        = '0;
    cy        = '0;
    for (int i = 0; i < COIN_COUNT; i++) begin
      cx  = COIN_POS[i*12 +: 12];
      sxU = (cx - offset_q) & WORLD_MASK;
      sx  = {{2{sxU[11]}}, sxU};
      cy  = $signed({4'd0, heightAt(cx)}) - 14'(COIN_LIFT);
      if (!taken_q[i] &&
          (sq($signed({4'd0, DrawX}) - sx) + sq($signed({4'd0, DrawY}) - cy)) <= HIT_R2)
        pixCoin = 1'b1;
      if (!taken_q[i] &&
          (sq(14'(STICK_X) - sx) + sq($signed({4'd0, StickY}) - cy)) <= GRAB_R2) begin
        grab[i]   = 1'b1;
        grabCount = grabCount + 8'd1;
      end
    end
  end

  assign coinSum    = {1'b0, coins_q} + {1'b0, grabCount};
  assign coins_d    = coinSum[8] ? 8'hFF : coinSum[7:0];
  assign is_coin    = pixCoin;
  assign coin_pulse = coinPulse_q;
  assign coins      = coins_q;
`else
  localparam logic unusedCoinCfg = ^{COIN_POS, 32'(COIN_R), 32'(COIN_LIFT)};
  logic unusedCoinInputs;

  assign unusedCoinInputs = ^StickY;
  assign is_coin          = 1'b0;
  assign coin_pulse       = 1'b0;
  assign coins            = 8'd0;
`endif

  // Dropping playing parks the FSM in IDLE before any scroll or pickup can happen.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= IDLE;
      offset_q <= '0;
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      sync3_q  <= 1'b0;
`ifdef TERRAIN_COIN_EN
      taken_q     <= '0;
      coins_q     <= '0;
      coinPulse_q <= 1'b0;
`endif
    end else begin
      sync1_q <= frame_clk;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
`ifdef TERRAIN_COIN_EN
      coinPulse_q <= 1'b0;
`endif
      if (!playing) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: state_q <= SCROLL;
          SCROLL: begin
            if (frameEvt) begin
              offset_q <= offset_d;
`ifdef TERRAIN_COIN_EN
              if (offset_d < offset_q) taken_q <= '0;
`endif
              state_q <= CHECK;
            end
          end
          CHECK: begin
`ifdef TERRAIN_COIN_EN
            if (|grab) begin
              taken_q     <= taken_q | grab;
              coins_q     <= coins_d;
              coinPulse_q <= 1'b1;
            end
`endif
            state_q <= SCROLL;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule
